// File: rtl/fp_div_pkg.sv
// Shared types and constants for the fp32 divider arbiter.
package fp_div_pkg;

    localparam int unsigned FP32_W = 32;
    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one multi-cycle fp32 divider between NUM_REQ valid/ready clients.
// One division in flight; round-robin grant; timeout abort returns a quiet NaN.
module fp_div_arbiter
    import fp_div_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FP32_W-1:0] req_a,
    input  logic [NUM_REQ*FP32_W-1:0] req_b,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [FP32_W-1:0]         rsp_result,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic                      rsp_err,
    output logic                      div_start,
    output logic [FP32_W-1:0]         div_a,
    output logic [FP32_W-1:0]         div_b,
    input  logic [FP32_W-1:0]         div_result,
    input  logic                      div_done,
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Acceptance is visible in the same IDLE cycle the winner is chosen.
    assign req_ready = (state == ST_IDLE) ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            tag_q      <= '0;
            cnt        <= '0;
            div_start  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        div_a     <= req_a[FP32_W*32'(grant_idx) +: FP32_W];
                        div_b     <= req_b[FP32_W*32'(grant_idx) +: FP32_W];
                        tag_q     <= req_tag[TAG_W*32'(grant_idx) +: TAG_W];
                        owner     <= grant_idx;
                        rr_ptr    <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                        : grant_idx + IDX_W'(1);
                        div_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    div_start <= 1'b0;
                    cnt       <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // cnt == 0 is the first WAIT cycle, where done may still be left over.
                    if (cnt != '0 && div_done) begin
                        rsp_result <= div_result;
                        rsp_err    <= 1'b0;
                        rsp_tag    <= tag_q;
                        rsp_valid  <= NUM_REQ'(1) << owner;
                        state      <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_result <= FP32_QNAN;
                        rsp_err    <= 1'b1;
                        rsp_tag    <= tag_q;
                        rsp_valid  <= NUM_REQ'(1) << owner;
                        state      <= ST_RESP;
                    end else if (cnt != CNT_W'(TIMEOUT)) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with a behavioural divider and a transaction-level reference model.
module tb_fp_div_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int DIV_LAT = 3;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*32-1:0]   req_a = '0;
    logic [NUM_REQ*32-1:0]   req_b = '0;
    logic [NUM_REQ*TAG_W-1:0] req_tag = '0;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [NUM_REQ-1:0]      rsp_ready = '0;
    logic [31:0]             rsp_result;
    logic [TAG_W-1:0]        rsp_tag;
    logic                    rsp_err;
    logic                    div_start;
    logic [31:0]             div_a;
    logic [31:0]             div_b;
    logic [31:0]             div_result = 32'hDEADBEEF;
    logic                    div_done = 1'b1;
    logic                    busy;

    fp_div_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .div_done   (div_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Quotients for the directed operand pairs; anything else gets an arbitrary but deterministic value.
    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            64'h40F00000_40200000: return 32'h40400000;
            64'h41000000_40000000: return 32'h40800000;
            64'h40A00000_00000000: return 32'h7F800000;
            64'h7FC00000_40000000: return 32'h7FC00000;
            default:               return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    // Behavioural divider: done is a level that lingers from the previous op for one cycle after start.
    bit          div_dead = 1'b0;
    bit          dv_pend  = 1'b0;
    int          dv_lat   = 0;
    logic [31:0] dv_next  = '0;
    always @(posedge clk) begin
        if (div_start) begin
            dv_pend <= 1'b1;
            dv_lat  <= DIV_LAT;
            dv_next <= quot(div_a, div_b);
        end else if (dv_pend) begin
            if (dv_lat == 1) begin
                dv_pend <= 1'b0;
                if (!div_dead) begin
                    div_done   <= 1'b1;
                    div_result <= dv_next;
                end
            end else begin
                dv_lat   <= dv_lat - 1;
                div_done <= 1'b0;
            end
        end
    end

    // Reference model: one outstanding transaction, free again the cycle after the response handshake.
    typedef struct {
        int          owner;
        logic [3:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
    } txn_t;

    txn_t cur;
    bit   m_free   = 1'b1;
    int   m_ptr    = 0;
    int   m_since  = -1;
    bit   post_rst = 1'b0;
    bit   rsp_seen = 1'b0;
    int   rsp_since = 0;
    int   n_starts = 0;
    int   g;
    int   c;
    int   grant_log[$];
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_vld;

    always @(negedge clk) begin
        if (rst) begin
            m_free   = 1'b1;
            m_ptr    = 0;
            m_since  = -1;
            post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                chk("post_reset_outputs",
                    {31'd0, div_start, rsp_valid, rsp_err, busy, div_a != 0, div_b != 0,
                     rsp_result != 0, rsp_tag != 0}, 64'd0);
                post_rst = 1'b0;
            end
            exp_ready = '0;
            g = -1;
            if (m_free) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("busy", 64'(busy), 64'(!m_free));
            chk("div_start", 64'(div_start), 64'(m_since == 0));
            if (div_start) n_starts++;
            if (!m_free) begin
                chk("div_a", 64'(div_a), 64'(cur.a));
                chk("div_b", 64'(div_b), 64'(cur.b));
                if (rsp_valid != '0) begin
                    if (!rsp_seen) begin
                        rsp_seen  = 1'b1;
                        rsp_since = m_since;
                    end
                    exp_vld = '0;
                    exp_vld[cur.owner] = 1'b1;
                    chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
                    chk("rsp_result", 64'(rsp_result), 64'(cur.res));
                    chk("rsp_tag", 64'(rsp_tag), 64'(cur.tag));
                    chk("rsp_err", 64'(rsp_err), 64'(cur.err));
                end else if (m_since > TIMEOUT + 4) begin
                    chk("rsp_overdue", 64'(m_since), 64'(TIMEOUT + 4));
                end
            end else begin
                chk("rsp_idle", 64'(rsp_valid), 64'd0);
            end
            if (m_free) begin
                if (g >= 0) begin
                    cur.owner = g;
                    cur.tag   = req_tag[TAG_W*g +: TAG_W];
                    cur.a     = req_a[32*g +: 32];
                    cur.b     = req_b[32*g +: 32];
                    cur.err   = div_dead;
                    cur.res   = div_dead ? QNAN : quot(cur.a, cur.b);
                    m_free    = 1'b0;
                    m_ptr     = (g + 1) % NUM_REQ;
                    m_since   = 0;
                    rsp_seen  = 1'b0;
                    grant_log.push_back(g);
                end
            end else begin
                m_since++;
                if (rsp_valid[cur.owner] && rsp_ready[cur.owner]) begin
                    m_free  = 1'b1;
                    m_since = -1;
                end
            end
        end
    end

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        req_a[32*r +: 32]       = a;
        req_b[32*r +: 32]       = b;
        req_tag[TAG_W*r +: TAG_W] = tag;
    endtask

    task automatic do_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        bit ok;
        ok = 1'b0;
        @(posedge clk) #1;
        set_req(r, a, b, tag);
        req_valid[r] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_accept_timeout", 64'd0, 64'd1);
        @(posedge clk) #1;
        req_valid[r] = 1'b0;
    endtask

    logic [31:0] got_res;
    logic [3:0]  got_tag;
    logic        got_err;

    // Wait for requester r's response, stall it for 'hold' cycles, then accept it.
    task automatic take_rsp(input int r, input int hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid[r]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
        got_res = rsp_result;
        got_tag = rsp_tag;
        got_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_hold_valid", 64'(rsp_valid[r]), 64'd1);
            chk("rsp_hold_result", 64'(rsp_result), 64'(got_res));
        end
        @(posedge clk) #1;
        rsp_ready[r] = 1'b1;
        @(posedge clk) #1;
        rsp_ready[r] = 1'b0;
        @(negedge clk);
    endtask

    int starts0;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_div_start", 64'(div_start), 64'd0);
        chk("reset_div_a", 64'(div_a), 64'd0);
        chk("reset_rsp_result", 64'(rsp_result), 64'd0);

        // Basic divide 7.5 / 2.5 on requester 0
        starts0 = n_starts;
        do_req(0, 32'h40F00000, 32'h40200000, 4'h5);
        take_rsp(0, 0);
        chk("t1_result", 64'(got_res), 64'h40400000);
        chk("t1_tag", 64'(got_tag), 64'h5);
        chk("t1_err", 64'(got_err), 64'd0);
        chk("t1_starts", 64'(n_starts - starts0), 64'd1);
        chk("t1_latency", 64'(rsp_since), 64'(DIV_LAT + 2));

        // Round robin from a fresh pointer with all four requesters permanently valid
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        grant_log.delete();
        for (int r = 0; r < NUM_REQ; r++)
            set_req(r, 32'h3F800000 + (r << 20), 32'h40000000 + r, 4'(r + 8));
        rsp_ready = '1;
        req_valid = '1;
        for (int i = 0; i < 200 && grant_log.size() < 5; i++) @(negedge clk);
        @(posedge clk) #1;
        req_valid = '0;
        for (int i = 0; i < 50 && !m_free; i++) @(negedge clk);
        rsp_ready = '0;
        chk("rr_count", 64'(grant_log.size()), 64'd5);
        if (grant_log.size() >= 5) begin
            chk("rr_g0", 64'(grant_log[0]), 64'd0);
            chk("rr_g1", 64'(grant_log[1]), 64'd1);
            chk("rr_g2", 64'(grant_log[2]), 64'd2);
            chk("rr_g3", 64'(grant_log[3]), 64'd3);
            chk("rr_g4", 64'(grant_log[4]), 64'd0);
        end

        // Back-pressured response from requester 1: 8.0 / 2.0
        do_req(1, 32'h41000000, 32'h40000000, 4'hA);
        take_rsp(1, 5);
        chk("t3_result", 64'(got_res), 64'h40800000);
        chk("t3_tag", 64'(got_tag), 64'hA);

        // Special values pass straight through from the divider
        do_req(2, 32'h40A00000, 32'h00000000, 4'h3);
        take_rsp(2, 0);
        chk("t4_inf", 64'(got_res), 64'h7F800000);
        chk("t4_inf_err", 64'(got_err), 64'd0);
        do_req(2, 32'h7FC00000, 32'h40000000, 4'h4);
        take_rsp(2, 1);
        chk("t4_nan", 64'(got_res), 64'h7FC00000);
        chk("t4_nan_err", 64'(got_err), 64'd0);

        // Divider never answers: forced abort after TIMEOUT WAIT cycles
        div_dead = 1'b1;
        do_req(3, 32'h40400000, 32'h3F800000, 4'hC);
        take_rsp(3, 0);
        div_dead = 1'b0;
        chk("t5_result", 64'(got_res), 64'(QNAN));
        chk("t5_err", 64'(got_err), 64'd1);
        chk("t5_tag", 64'(got_tag), 64'hC);
        chk("t5_latency", 64'(rsp_since), 64'(TIMEOUT + 1));
        @(negedge clk);
        chk("t5_idle", 64'(busy), 64'd0);

        // Reset in WAIT: operation dropped, late done ignored
        do_req(0, 32'h40F00000, 32'h40200000, 4'h6);
        @(negedge clk);
        chk("t6_in_wait", 64'(busy), 64'd1);
        @(posedge clk) #1 rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_div_b", 64'(div_b), 64'd0);
        repeat (10) @(negedge clk);
        chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
        chk("t6_still_idle", 64'(busy), 64'd0);

        // Normal operation afterwards, with a stale done present at issue time
        do_req(1, 32'h41000000, 32'h40000000, 4'h2);
        take_rsp(1, 0);
        chk("t7_result", 64'(got_res), 64'h40800000);
        chk("t7_tag", 64'(got_tag), 64'h2);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
